// File: rtl/dp4_feeder.sv
// dp4_feeder: gathers eight operand words into a load buffer, launches them as
// one vector into an external DP4 pipeline, captures each tagged result into
// a small FIFO and hands results to a consumer in launch order. Launches only
// happen when the FIFO is guaranteed to have room for the result.
module dp4_feeder #(
  parameter int LAT    = 3,
  parameter int RDEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [255:0] dp_vec,
  input  logic [31:0]  dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [15:0]  job_cnt
);

  localparam int AW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  // wide enough for fifo_cnt + inflight without overflow
  localparam int CW = $clog2(2 * RDEPTH + 1);

  logic [2:0]    wcnt;
  logic          full;
  logic [31:0]   slots [8];
  logic [255:0]  slot_flat;
  logic [LAT:0]  tag_sr;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] credit_sum;
  logic [31:0]   fifo_mem [RDEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          launch;
  logic          accept;
  logic          push;
  logic          pop;

  // Credits count both queued results and results still in the DP4 pipe,
  // so a launched job always finds a free FIFO entry when it returns.
  assign credit_sum = fifo_cnt + inflight;
  assign launch     = full && (credit_sum < CW'(RDEPTH));
  assign in_ready   = rst && (!full || launch);
  assign accept     = in_valid && in_ready;
  assign push       = tag_sr[LAT];
  assign out_valid  = rst && (fifo_cnt != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? fifo_mem[rptr] : '0;

  // Flatten slots so slot 0 (a0) lands in the least significant word.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_flat
      assign slot_flat[gi*32 +: 32] = slots[gi];
    end
  endgenerate

  // Load buffer storage; contents are don't-care until fully written.
  always_ff @(posedge clk) begin
    if (accept) slots[wcnt] <= in_data;
  end

  // Load buffer write counter and full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
      full <= 1'b0;
    end else begin
      if (launch) wcnt <= accept ? 3'd1 : 3'd0;
      else if (accept) wcnt <= wcnt + 3'd1;
      if (accept && (wcnt == 3'd7)) full <= 1'b1;
      else if (launch) full <= 1'b0;
    end
  end

  // Operand register for the DP4 plus the tag that marks its result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_vec   <= '0;
      tag_sr   <= '0;
      inflight <= '0;
    end else begin
      if (launch) dp_vec <= slot_flat;
      tag_sr   <= {tag_sr[LAT-1:0], launch};
      inflight <= inflight + CW'(launch) - CW'(push);
    end
  end

  // Result FIFO storage, written when a tag exits the shift register.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= dp_result;
  end

  // Result FIFO pointers, occupancy and popped-job counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      job_cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr    <= rptr + AW'(1);
        job_cnt <= job_cnt + 16'd1;
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule
